ld_st_issue_ctrl: RTL
=====================

Name: ld_st_issue_ctrl

Overview:
- In-order issue controller sitting between the load/store tag queue, the load/store reservation stations, and the data-memory port.
- Pops the oldest reservation-station tag, waits until that station's operands are ready, and computes the effective address as base + immediate.
- Issues one memory request with a req/ack handshake, then broadcasts completion of that tag.
- Exactly one memory operation is in flight at a time; memory order equals queue order.

Parameters:
TAG_W, 4, width of a reservation-station tag
NUM_RS, 16, number of reservation stations indexed by tag (must be <= 2^TAG_W)
ADDR_W, 32, address/operand width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
q_empty  in  1  tag queue empty
q_tag  in  TAG_W  queue read data; valid the cycle after q_rd_en
q_rd_en  out  1  pop one entry from the tag queue
rs_ready  in  NUM_RS  per-station bit: base (and store data) operands available
rs_is_store  in  NUM_RS  per-station bit: 1 = store, 0 = load
rs_sel  out  TAG_W  station index whose operands are read (= cur_tag)
rs_base  in  ADDR_W  base operand of station rs_sel (combinational)
rs_imm  in  ADDR_W  immediate offset of station rs_sel (combinational)
mem_req  out  1  memory request valid
mem_we  out  1  1 = store, 0 = load
mem_addr  out  ADDR_W  effective address
mem_tag  out  TAG_W  tag of the request
mem_ack  in  1  memory accepted/completed the request
flush  in  1  synchronous squash of the operation in progress
done_valid  out  1  one-cycle completion pulse
done_tag  out  TAG_W  tag completed; valid with done_valid
busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, any cycle): state=IDLE; cur_tag, mem_addr, mem_tag=0; mem_req, mem_we, q_rd_en, done_valid=0; flush_pend=0. Reset during ISSUE drops mem_req immediately; that operation is lost.
- States: IDLE, POP, LATCH, WAIT_RDY, ISSUE, DONE. q_rd_en, mem_req, done_valid and busy are decoded from state.
- IDLE: if !q_empty go to POP, else stay.
- POP: q_rd_en=1 for exactly this cycle; next state LATCH.
- LATCH: cur_tag <= q_tag; next state WAIT_RDY.
- WAIT_RDY: rs_sel=cur_tag. When rs_ready[cur_tag]=1:
  - register mem_addr <= (rs_base + rs_imm) mod 2^ADDR_W (carry discarded);
  - register mem_we <= rs_is_store[cur_tag] and mem_tag <= cur_tag;
  - go to ISSUE.
  - Otherwise hold indefinitely.
- ISSUE: mem_req=1; mem_addr, mem_we and mem_tag are held stable until mem_ack. On mem_ack, go to DONE. An ack in the first ISSUE cycle is legal. mem_ack outside ISSUE is ignored.
- DONE: done_valid=1 and done_tag=cur_tag unless flush_pend=1, in which case done_valid stays 0. Clear flush_pend; next state IDLE.
- Minimum latency (queue non-empty in IDLE, operands ready, ack immediate) is 5 cycles: IDLE->POP->LATCH->WAIT_RDY->ISSUE->DONE. done_valid asserts 5 cycles after the first IDLE cycle with q_empty=0. Throughput is 1 op per 6 cycles minimum.
- Flush in IDLE, POP, LATCH or WAIT_RDY: next state IDLE. An entry popped in POP is discarded; no memory request and no done pulse are produced.
- Flush in ISSUE: the request cannot be withdrawn. Set flush_pend, keep mem_req until mem_ack, then pass through DONE with done_valid suppressed.
- Flush in DONE: no effect on the current pulse.
- Flush and mem_ack in the same ISSUE cycle: go to DONE with done_valid suppressed.
- q_empty is sampled only in IDLE. An entry arriving while busy waits in the queue.
- cur_tag >= NUM_RS is illegal input. The controller treats it as never ready (stays in WAIT_RDY until flush).

Test Plan:
- Basic load: queue holds tag 3; rs_ready[3]=1, rs_is_store[3]=0, rs_base=0x1000, rs_imm=0x24; mem_ack on the first ISSUE cycle -> mem_req with mem_addr=0x1024, mem_we=0, mem_tag=3; q_rd_en asserts exactly once; done_valid with done_tag=3 exactly 5 cycles after IDLE sees q_empty=0.
- Ordering and stall: queue holds 5 then 2; rs_ready[5]=0 for 10 cycles while rs_ready[2]=1 -> no mem_req until rs_ready[5] rises; completions are tag 5 then tag 2; q_rd_en asserts twice.
- Store with wrap and slow ack: tag 7 is a store, rs_base=0xFFFFFFF0, rs_imm=0x20; mem_ack delayed 4 cycles -> mem_addr=0x00000010, mem_we=1; mem_addr, mem_we and mem_tag are stable all 4 ISSUE cycles; a single done pulse follows.
- Flush while waiting: flush asserted in WAIT_RDY for tag 4 -> state IDLE next cycle; no mem_req and no done for tag 4; the next queued tag is processed normally.
- Flush in ISSUE: flush for 1 cycle while mem_req=1, mem_ack 2 cycles later -> mem_req held until ack; done_valid stays 0; busy=0 one cycle after DONE. Repeat with flush and mem_ack in the same cycle -> same result.
- Async reset: assert rst mid-ISSUE, deasserted between clock edges -> mem_req, busy, done_valid and q_rd_en are 0 immediately; state IDLE; normal operation resumes on the next non-empty queue.

Source files
------------

// File: rtl/ld_st_issue_ctrl.sv
//------------------------------------------------------------------------------
// ld_st_issue_ctrl
//
// In-order load/store issue controller. Pops the oldest reservation-station
// tag from the tag queue, waits for that station's operands, forms the
// effective address (base + immediate, wrapping), issues a single memory
// request with a req/ack handshake and then broadcasts completion of the tag.
// Only one memory operation is ever in flight, so memory order equals queue
// order.
//
// Ports:
//   clk, rst                       clock (rising edge), async active-high reset
//   q_empty, q_tag, q_rd_en        tag queue interface (q_tag valid the cycle
//                                  after q_rd_en)
//   rs_ready, rs_is_store          per-station operand-ready / store flags
//   rs_sel, rs_base, rs_imm        station select and its combinational operands
//   mem_req, mem_we, mem_addr,
//   mem_tag, mem_ack               data-memory request handshake
//   flush                          synchronous squash of the op in progress
//   done_valid, done_tag           one-cycle completion broadcast
//   busy                           controller not idle
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module ld_st_issue_ctrl #(
    parameter int TAG_W  = 4,
    parameter int NUM_RS = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              q_empty,
    input  logic [TAG_W-1:0]  q_tag,
    output logic              q_rd_en,
    input  logic [NUM_RS-1:0] rs_ready,
    input  logic [NUM_RS-1:0] rs_is_store,
    output logic [TAG_W-1:0]  rs_sel,
    input  logic [ADDR_W-1:0] rs_base,
    input  logic [ADDR_W-1:0] rs_imm,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [TAG_W-1:0]  mem_tag,
    input  logic              mem_ack,
    input  logic              flush,
    output logic              done_valid,
    output logic [TAG_W-1:0]  done_tag,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LATCH,
        WAIT_RDY,
        ISSUE,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [TAG_W-1:0]  cur_tag;
    logic              flush_pend;
    logic              sel_ready;
    logic              sel_store;

    // Effective address: carry out of the top bit is discarded.
    function automatic logic [ADDR_W-1:0] eff_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [ADDR_W-1:0] imm);
        return base + imm;
    endfunction

    // Station lookup by cur_tag. A tag with no matching station never
    // matches, so it reads as not ready and the controller waits for a flush.
    always_comb begin
        sel_ready = 1'b0;
        sel_store = 1'b0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (cur_tag == TAG_W'(i)) begin
                sel_ready = rs_ready[i];
                sel_store = rs_is_store[i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!flush && !q_empty) begin
                    state_nxt = POP;
                end
            end
            POP: begin
                state_nxt = flush ? IDLE : LATCH;
            end
            LATCH: begin
                state_nxt = flush ? IDLE : WAIT_RDY;
            end
            WAIT_RDY: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (sel_ready) begin
                    state_nxt = ISSUE;
                end
            end
            // The request cannot be withdrawn once raised, so flush only
            // marks the completion for suppression.
            ISSUE: begin
                if (mem_ack) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cur_tag    <= '0;
            mem_addr   <= '0;
            mem_tag    <= '0;
            mem_we     <= 1'b0;
            flush_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == LATCH) begin
                cur_tag <= q_tag;
            end
            if (state == WAIT_RDY && !flush && sel_ready) begin
                mem_addr <= eff_addr(rs_base, rs_imm);
                mem_we   <= sel_store;
                mem_tag  <= cur_tag;
            end
            if (state == ISSUE && flush) begin
                flush_pend <= 1'b1;
            end else if (state == DONE) begin
                flush_pend <= 1'b0;
            end
        end
    end

    assign q_rd_en    = (state == POP);
    assign mem_req    = (state == ISSUE);
    assign done_valid = (state == DONE) && !flush_pend;
    assign done_tag   = cur_tag;
    assign busy       = (state != IDLE);
    assign rs_sel     = cur_tag;

endmodule
